// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA raster timing generator: default 640x480@60
// timing, pattern mode encodings and the 1-bit-per-channel colour-bar table.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned FRAME_CNT_W   = 8;

    typedef enum logic [1:0] {
        MODE_WHITE = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_ANIM  = 2'd3
    } mode_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb1_t;

    // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black
    function automatic rgb1_t bar_rgb(input logic [2:0] idx);
        rgb1_t c;
        case (idx)
            3'd0:    c = rgb1_t'(3'b111);
            3'd1:    c = rgb1_t'(3'b110);
            3'd2:    c = rgb1_t'(3'b011);
            3'd3:    c = rgb1_t'(3'b010);
            3'd4:    c = rgb1_t'(3'b101);
            3'd5:    c = rgb1_t'(3'b100);
            3'd6:    c = rgb1_t'(3'b001);
            default: c = rgb1_t'(3'b000);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pattern.sv
// Test-pattern source: registers one RGB pixel per pix_en update, aligned with the
// timing outputs. Bar index is tracked by a sub-counter instead of dividing x.
module vga_pattern_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned COLOR_W    = 4,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               de,
    input  logic [CNT_W-1:0]   x,
    input  logic               chk_y,
    input  mode_e              mode_q,
    input  logic               anim_phase,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int unsigned BAR_W = H_VISIBLE / 8;
    localparam logic [CNT_W-1:0] H_LAST_CNT = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] BAR_LAST   = CNT_W'(BAR_W - 1);

    logic [CNT_W-1:0]   bar_px_q, bar_px_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    rgb1_t              pix_c;

    // Pixel colour for the current counter position
    always_comb begin
        pix_c = rgb1_t'(3'b000);
        case (mode_q)
            MODE_WHITE: pix_c = rgb1_t'(3'b111);
            MODE_BARS:  pix_c = bar_rgb(bar_idx_q);
            MODE_CHECK: pix_c = {3{x[CHECK_LOG2] ^ chk_y}};
            MODE_ANIM:  pix_c = {3{x[CHECK_LOG2] ^ chk_y ^ anim_phase}};
            default:    pix_c = rgb1_t'(3'b000);
        endcase
    end

    // Bar sub-counter tracks the pixel currently on h_cnt; restarts with every line
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        if (pix_en) begin
            if (x == H_LAST_CNT) begin
                bar_px_d  = '0;
                bar_idx_d = '0;
            end else if (bar_px_q == BAR_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d  = bar_px_q + CNT_W'(1);
            end
            red_d   = de ? {COLOR_W{pix_c.r}} : '0;
            green_d = de ? {COLOR_W{pix_c.g}} : '0;
            blue_d  = de ? {COLOR_W{pix_c.b}} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with built-in test patterns.
// Optional macro VGA_FRAME_ANIM_EN builds a live frame counter and animates mode 3.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter logic        HS_ACTIVE  = 1'b0,
    parameter logic        VS_ACTIVE  = 1'b0,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned COLOR_W    = 4,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic [1:0]         mode,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_CNT  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_LAST_CNT = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEG_CNT = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END_CNT = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_VIS_CNT  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_LAST_CNT = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] VS_BEG_CNT = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END_CNT = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    mode_e            mode_q, mode_d;
    logic             h_last_c, v_last_c, de_c, frame_end_c, anim_phase_c;

    assign h_last_c    = (h_cnt_q == H_LAST_CNT);
    assign v_last_c    = (v_cnt_q == V_LAST_CNT);
    assign de_c        = (h_cnt_q < H_VIS_CNT) && (v_cnt_q < V_VIS_CNT);
    assign frame_end_c = pix_en && h_last_c && v_last_c;

    // Counters advance and outputs capture the current position on pix_en; strobes self-clear
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        mode_d        = mode_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_en) begin
            h_cnt_d = h_last_c ? '0 : h_cnt_q + CNT_W'(1);
            if (h_last_c) begin
                v_cnt_d = v_last_c ? '0 : v_cnt_q + CNT_W'(1);
            end
            hs_d          = (h_cnt_q >= HS_BEG_CNT && h_cnt_q <= HS_END_CNT) ? HS_ACTIVE : ~HS_ACTIVE;
            vs_d          = (v_cnt_q >= VS_BEG_CNT && v_cnt_q <= VS_END_CNT) ? VS_ACTIVE : ~VS_ACTIVE;
            de_d          = de_c;
            x_d           = h_cnt_q;
            y_d           = v_cnt_q;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        end
        // Mode only changes across a frame boundary so a frame is never torn
        if (frame_end_c) begin
            mode_d = mode_e'(mode);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_q          <= ~HS_ACTIVE;
            vs_q          <= ~VS_ACTIVE;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            mode_q        <= MODE_WHITE;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            mode_q        <= mode_d;
        end
    end

`ifdef VGA_FRAME_ANIM_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Steps at the frame boundary so each frame carries one value, including its first pixel
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_end_c) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt    = frame_cnt_q;
    assign anim_phase_c = frame_cnt_q[0];
`else
    assign frame_cnt    = '0;
    assign anim_phase_c = 1'b0;
`endif

    vga_pattern_gen #(
        .H_TOTAL    (H_TOTAL),
        .H_VISIBLE  (H_VISIBLE),
        .CNT_W      (CNT_W),
        .COLOR_W    (COLOR_W),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_pattern (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .de         (de_c),
        .x          (h_cnt_q),
        .chk_y      (v_cnt_q[CHECK_LOG2]),
        .mode_q     (mode_q),
        .anim_phase (anim_phase_c),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with a built-in test-pattern source.
- Produces registered HS/VS, data-enable, pixel X/Y coordinates, frame/line strobes and RGB from a selectable pattern.
- Sits between the clock-wizard pixel clock (or a faster clock with a pixel enable) and the board VGA connector.
- Any resolution is supported through timing parameters.

Parameters:
- H_VISIBLE, 640, active pixels per line (must be divisible by 8)
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_ACTIVE, 0, HS level during sync (0 = active-low)
- VS_ACTIVE, 0, VS level during sync (0 = active-low)
- CNT_W, 10, counter / coordinate width; H_TOTAL and V_TOTAL must be <= 2^CNT_W
- COLOR_W, 4, bits per colour channel
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-advance enable; tie to 1 when clk is the pixel clock
- mode  in  2  pattern select: 0 white, 1 colour bars, 2 checkerboard, 3 animated checkerboard
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  data enable (visible region)
- x  out  CNT_W  pixel column, valid when de=1
- y  out  CNT_W  pixel row, valid when de=1
- line_start  out  1  one-clk pulse at x=0 of every line (visible and blanking)
- frame_start  out  1  one-clk pulse at pixel (0,0)
- frame_cnt  out  8  frame counter
- red, green, blue  out  COLOR_W each  pixel colour; 0 whenever de=0

Behaviour:
- Totals: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 × 525.
- Counters:
  - Internal h_cnt/v_cnt advance only on pix_en cycles.
  - h_cnt wraps H_TOTAL-1 → 0. v_cnt increments when h_cnt wraps, and wraps V_TOTAL-1 → 0.
- Counter region order per axis: visible [0, VIS-1], front porch, sync, back porch.
- Sync windows:
  - hs active for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (default 656..751).
  - vs active for v_cnt in [V_VISIBLE+V_FRONT, ... +V_SYNC-1] (default 490..491).
- de = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE). x = h_cnt, y = v_cnt.
- Latency:
  - All outputs are registered, updated on pix_en cycles only, and reflect the counter value from that same cycle: exactly one pix_en update of latency.
  - RGB is aligned with de/x/y; no extra stage is visible at the ports.
- Strobes:
  - line_start and frame_start assert for exactly one clk after the pix_en update where h_cnt=0 (resp. h_cnt=0 and v_cnt=0).
  - They clear on the next clk regardless of pix_en.
- Mode latch:
  - mode is sampled into mode_q only on the pix_en cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
  - A mode change mid-frame takes effect at the next frame; there is never any tearing.
- Patterns (channel full-scale F = all ones):
  - Mode 0: R=G=B=F.
  - Mode 1: 8 vertical bars, each BAR_W = H_VISIBLE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black.
    - Bar index comes from a bar sub-counter, reset at x=0 and incremented every BAR_W pixels. No divider.
  - Mode 2: white when x[CHECK_LOG2]^y[CHECK_LOG2] = 1, else black.
  - Mode 3: checkerboard as mode 2 but XORed with frame_cnt[0] (see Optional Feature).
- frame_cnt increments (mod 256) on each frame_start.
- Reset (rst low, async):
  - h_cnt = v_cnt = 0, mode_q = 0, frame_cnt = 0.
  - hs = ~HS_ACTIVE, vs = ~VS_ACTIVE.
  - de, x, y, strobes and rgb = 0.
- Reset release: the first pix_en update outputs pixel (0,0) with de=1 and frame_start pulses. Reset asserted mid-frame returns to this state immediately.
- pix_en held low: all outputs and counters hold, except the strobes, which clear.

Optional Feature:
- Macro VGA_FRAME_ANIM_EN.
- Defined: frame_cnt is live; mode 3 phase-inverts the checkerboard every frame.
- Undefined: frame_cnt is tied to 0; mode 3 is identical to mode 2; no frame counter flops are built.

Decomposition:
- Package vga_timing_pkg:
  - default 640×480@60 timing constants;
  - mode encodings (MODE_WHITE, MODE_BARS, MODE_CHECK, MODE_ANIM);
  - 8-entry colour-bar RGB table (1 bit/channel, expanded to COLOR_W).
- Sub-module vga_pattern_gen:
  - takes de, x, y, mode_q, frame_cnt and returns rgb;
  - holds the bar sub-counter;
  - is purely pix_en-qualified.

Test Plan:
- Reset then pix_en=1 for 2 frames → hs period 800 clks, low for 96 clks starting at x-count 656; vs low for 1600 clks; frame_start pulses every 420000 clks.
- pix_en toggling 1-of-4 clks → all periods scale ×4; outputs stable between enables; strobe width exactly 1 clk.
- mode=1 → at y=100, rgb changes at x=80,160,…,560; x=0 white F/F/F; x=600 black; rgb=0 at x=700.
- mode switched 0→2 at y=200 → rest of frame stays white; next frame checkerboard: (0,0) black, (32,0) white, (32,32) black.
- Reset asserted at x=300,y=300 → outputs immediately take reset values; after release, first pixel is (0,0) and frame_cnt=0.
- With VGA_FRAME_ANIM_EN, mode=3 → pixel (0,0) alternates black/white on successive frames; frame_cnt wraps 255→0. Without the macro → static, frame_cnt=0.
